// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request, encoded-word and address-load signals of the instruction encoder
interface inst_encoder_if #(parameter int ADDR_WIDTH = 32);
  logic req_valid;
  logic req_ready;
  logic [2:0] req_fmt;
  logic [6:0] req_opcode;
  logic [4:0] req_rd;
  logic [4:0] req_rs1;
  logic [4:0] req_rs2;
  logic [2:0] req_funct3;
  logic [6:0] req_funct7;
  logic [31:0] req_imm;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic addr_load;
  logic [ADDR_WIDTH-1:0] addr_val;
  logic err;
  modport master (
    output req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    output out_ready, addr_load, addr_val,
    input req_ready, out_valid, out_inst, out_addr, err
  );
  modport slave (
    input req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm,
    input out_ready, addr_load, addr_val,
    output req_ready, out_valid, out_inst, out_addr, err
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs register fields and immediates into RV32I words, expanding LI into LUI+ADDI
module inst_encoder #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input logic clk,
  input logic rst,
  inst_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, LI2} state_t;
  state_t state;
  logic [31:0] word, addi_word, pend_word;
  logic [19:0] hi;
  logic signed [31:0] simm;
  logic fits12, legal, li_two, acc;
  assign simm = bus.req_imm;
  assign fits12 = simm >= -2048 && simm <= 2047;
  assign hi = 20'((bus.req_imm + 32'h800) >> 12);
  assign addi_word = {bus.req_imm[11:0], fits12 ? 5'd0 : bus.req_rd, 3'b000, bus.req_rd, 7'b0010011};
  assign bus.req_ready = state == IDLE || (state == HOLD && bus.out_ready);
  assign acc = bus.req_valid && bus.req_ready;
  // field packing and immediate range check for the presented request
  always_comb begin
    word = '0;
    legal = 1'b1;
    li_two = 1'b0;
    case (bus.req_fmt)
      3'd0: word = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode};
      3'd1: begin
        word = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode};
        legal = fits12;
      end
      3'd2: begin
        word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_imm[4:0], bus.req_opcode};
        legal = fits12;
      end
      3'd3: begin
        word = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                bus.req_imm[4:1], bus.req_imm[11], bus.req_opcode};
        legal = !bus.req_imm[0] && simm >= -4096 && simm <= 4094;
      end
      3'd4: begin
        word = {bus.req_imm[31:12], bus.req_rd, bus.req_opcode};
        legal = bus.req_imm[11:0] == 12'd0;
      end
      3'd5: begin
        word = {bus.req_imm[20], bus.req_imm[10:1], bus.req_imm[11], bus.req_imm[19:12], bus.req_rd, bus.req_opcode};
        legal = !bus.req_imm[0] && simm >= -1048576 && simm <= 1048574;
      end
      3'd6: begin
        li_two = !fits12;
        word = fits12 ? addi_word : {hi, bus.req_rd, 7'b0110111};
      end
      default: legal = 1'b0;
    endcase
  end
  // output register, LI expansion state, error pulse and address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_inst <= '0;
      bus.out_addr <= RESET_ADDR;
      bus.err <= 1'b0;
      pend_word <= '0;
    end else begin
      bus.err <= acc && !legal;
      bus.out_addr <= bus.addr_load ? bus.addr_val
                    : (bus.out_valid && bus.out_ready) ? bus.out_addr + ADDR_WIDTH'(4) : bus.out_addr;
      if (acc && legal) begin
        bus.out_inst <= word;
        bus.out_valid <= 1'b1;
        pend_word <= addi_word;
        state <= li_two ? LI2 : HOLD;
      end else if (acc || (state == HOLD && bus.out_ready)) begin
        bus.out_valid <= 1'b0;
        state <= IDLE;
      end else if (state == LI2 && bus.out_ready) begin
        bus.out_inst <= pend_word;
        state <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized checks of inst_encoder against a word-queue reference model
module tb_inst_encoder;
  localparam logic [31:0] RESET_ADDR = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit err_exp = 1'b0;
  logic [31:0] exp_addr = RESET_ADDR;
  logic [31:0] q[$];
  inst_encoder_if #(.ADDR_WIDTH(32)) bus ();
  inst_encoder #(.ADDR_WIDTH(32), .RESET_ADDR(RESET_ADDR)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_enc(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [31:0] imm,
                                  output logic [31:0] w0, output logic [31:0] w1, output int n);
    int si;
    bit even;
    logic [31:0] hi, regs;
    si = $signed(imm);
    even = (imm & 32'h1) == 0;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    w0 = '0;
    w1 = '0;
    n = 1;
    case (fmt)
      3'd0: w0 = regs | (32'(f7) << 25) | (32'(rd) << 7);
      3'd1: begin
        n = (si >= -2048 && si <= 2047) ? 1 : 0;
        w0 = (imm << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
      end
      3'd2: begin
        n = (si >= -2048 && si <= 2047) ? 1 : 0;
        w0 = regs | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd3: begin
        n = (even && si >= -4096 && si <= 4094) ? 1 : 0;
        w0 = regs | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (((imm >> 1) & 15) << 8)
           | (((imm >> 11) & 1) << 7);
      end
      3'd4: begin
        n = ((imm & 32'hFFF) == 0) ? 1 : 0;
        w0 = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      3'd5: begin
        n = (even && si >= -1048576 && si <= 1048574) ? 1 : 0;
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
           | (((imm >> 12) & 255) << 12) | (32'(rd) << 7) | 32'(op);
      end
      3'd6: begin
        if (si >= -2048 && si <= 2047) begin
          w0 = (imm << 20) | (32'(rd) << 7) | 32'h13;
        end else begin
          n = 2;
          hi = (imm + 32'h800) >> 12;
          w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
          w1 = (imm << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
        end
      end
      default: n = 0;
    endcase
  endfunction

  task automatic step();
    logic [31:0] w0, w1;
    int n;
    bit acc, errn;
    #1;
    if (chk_en) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("req_ready", 32'(bus.req_ready), 32'(q.size() == 0 || (q.size() == 1 && bus.out_ready)));
      chk("err", 32'(bus.err), 32'(err_exp));
      if (q.size() != 0) begin
        chk("out_inst", bus.out_inst, q[0]);
        chk("out_addr", bus.out_addr, exp_addr);
      end
    end
    acc = bus.req_valid && (q.size() == 0 || (q.size() == 1 && bus.out_ready));
    if (q.size() != 0 && bus.out_ready) begin
      void'(q.pop_front());
      exp_addr += 4;
    end
    if (bus.addr_load) exp_addr = bus.addr_val;
    errn = 1'b0;
    if (acc) begin
      ref_enc(bus.req_fmt, bus.req_opcode, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_funct3,
              bus.req_funct7, bus.req_imm, w0, w1, n);
      if (n == 0) errn = 1'b1;
      if (n > 0) q.push_back(w0);
      if (n > 1) q.push_back(w1);
    end
    if (rst) begin
      q.delete();
      exp_addr = RESET_ADDR;
      errn = 1'b0;
    end
    @(negedge clk);
    err_exp = errn;
  endtask

  task automatic setreq(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    bus.req_valid = 1'b1;
    bus.req_fmt = fmt;
    bus.req_opcode = op;
    bus.req_rd = rd;
    bus.req_rs1 = rs1;
    bus.req_rs2 = rs2;
    bus.req_funct3 = f3;
    bus.req_funct7 = f7;
    bus.req_imm = imm;
  endtask

  task automatic reset_step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges[8] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, -32'd4096, 32'd1048574, -32'd1048576};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return $urandom & 32'hFFFFF000;
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  initial begin
    setreq(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.addr_load = 1'b0;
    bus.addr_val = '0;
    @(negedge clk);
    repeat (2) step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_out_addr", bus.out_addr, RESET_ADDR);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    setreq(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    step();
    bus.req_valid = 1'b0;
    chk("addi_inst", bus.out_inst, 32'hFFF00293);
    chk("addi_addr", bus.out_addr, 32'h0);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    step();

    reset_step();
    setreq(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    step();
    bus.req_valid = 1'b0;
    chk("beq_inst", bus.out_inst, 32'h00208463);
    step();
    setreq(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    step();
    bus.req_valid = 1'b0;
    chk("b_odd_err", 32'(bus.err), 32'd1);
    chk("b_odd_valid", 32'(bus.out_valid), 32'd0);
    chk("b_odd_addr", bus.out_addr, 32'h4);
    step();
    chk("b_odd_err_end", 32'(bus.err), 32'd0);

    reset_step();
    bus.out_ready = 1'b0;
    setreq(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    step();
    bus.req_valid = 1'b0;
    chk("li_lui", bus.out_inst, 32'h12346537);
    chk("li2_ready", 32'(bus.req_ready), 32'd0);
    repeat (3) step();
    chk("li_lui_hold", bus.out_inst, 32'h12346537);
    chk("li_lui_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    step();
    chk("li_addi", bus.out_inst, 32'hFFF50513);
    chk("li_addi_addr", bus.out_addr, 32'h4);
    step();

    setreq(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FF);
    step();
    bus.req_valid = 1'b0;
    chk("li_7ff", bus.out_inst, 32'h7FF00513);
    step();
    chk("li_7ff_single", 32'(bus.out_valid), 32'd0);
    setreq(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    step();
    bus.req_valid = 1'b0;
    chk("li_800_lui", bus.out_inst, 32'h00001537);
    step();
    chk("li_800_addi", bus.out_inst, 32'h80050513);
    step();

    setreq(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    chk("i_2048_err", 32'(bus.err), 32'd1);
    chk("i_2048_valid", 32'(bus.out_valid), 32'd0);
    setreq(3'd7, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step();
    bus.req_valid = 1'b0;
    chk("fmt7_err", 32'(bus.err), 32'd1);
    chk("fmt7_valid", 32'(bus.out_valid), 32'd0);
    step();

    setreq(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    step();
    setreq(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
    bus.addr_load = 1'b1;
    bus.addr_val = 32'h100;
    step();
    bus.addr_load = 1'b0;
    bus.req_valid = 1'b0;
    chk("load_inst", bus.out_inst, 32'h40628233);
    chk("load_addr", bus.out_addr, 32'h100);
    step();

    bus.out_ready = 1'b0;
    setreq(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    step();
    bus.req_valid = 1'b0;
    reset_step();
    chk("li2_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("li2_rst_addr", bus.out_addr, RESET_ADDR);
    chk("li2_rst_ready", 32'(bus.req_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("li2_rst_no_addi", 32'(bus.out_valid), 32'd0);

    repeat (800) begin
      setreq(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), rand_imm());
      bus.req_valid = $urandom_range(0, 9) < 7;
      bus.out_ready = $urandom_range(0, 9) < 7;
      bus.addr_load = $urandom_range(0, 19) == 0;
      bus.addr_val = $urandom_range(0, 1) ? 32'hFFFFFFF8 : $urandom;
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.addr_load = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
